accel_uart_framer: RTL and testbench

Parametrised frame builder between the SPI accelerometer controller and the byte-wide UART transmitter. It latches a multi-axis sample word, optionally decimates the sample stream, and emits a framed packet to the UART: sync byte, sequence number, all axis bytes, then an XOR checksum. This replaces the single-byte path that sent only the top 8 bits of the sample register. Samples arriving while a frame is in flight are dropped and counted.

---
 rtl/accel_uart_framer.sv | 157 +++++++++++++++
 tb/tb_accel_uart_framer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/accel_uart_framer.sv
// accel_uart_framer: latches a multi-axis accelerometer sample, optionally
// decimates the strobe stream, and sends a framed packet to a byte UART:
// SYNC, seq, axis bytes (axis 0 first, MSB first), XOR checksum of seq+data.
module accel_uart_framer #(
    parameter int          NUM_AXES  = 3,
    parameter int          AXIS_W    = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          DECIM     = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_AXES*AXIS_W-1:0]   i_sample,
    input  logic                         i_sample_vld,
    input  logic                         i_tx_ready,
    output logic                         o_tx_enb,
    output logic [7:0]                   o_tx_byte,
    output logic                         o_busy,
    output logic [7:0]                   o_seq,
    output logic [7:0]                   o_drop_cnt
);

    localparam int          BPA       = (AXIS_W + 7) / 8;
    localparam int          NDATA     = NUM_AXES * BPA;
    localparam int          FRAME_LEN = 3 + NDATA;
    localparam int          IDXW      = 6;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FRAME_LEN - 1);
    localparam logic [7:0]  DLAST     = 8'(DECIM - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_LOW, WAIT_HIGH} state_t;

    state_t              r_state;
    logic [IDXW-1:0]     r_idx;
    logic [1:0]          r_wcnt;
    logic [7:0]          r_dcnt;
    logic [NDATA*8-1:0]  r_data;
    logic [7:0]          r_chk;
    logic                r_tx_enb;
    logic [7:0]          r_tx_byte;
    logic [7:0]          r_seq;
    logic [7:0]          r_drop;

    logic [NDATA*8-1:0]  w_pad;
    logic [7:0]          w_byte;
    logic                w_sel;
    logic                w_accept;

    // Zero-extend each axis to a whole number of bytes.
    always_comb begin
        w_pad = '0;
        for (int unsigned a = 0; a < NUM_AXES; a++) begin
            w_pad[a*BPA*8 +: AXIS_W] = i_sample[a*AXIS_W +: AXIS_W];
        end
    end

    // Select the frame byte addressed by r_idx.
    always_comb begin
        w_byte = '0;
        if (r_idx == '0) begin
            w_byte = SYNC_BYTE;
        end else if (r_idx == IDXW'(1)) begin
            w_byte = r_seq;
        end else if (r_idx == LAST_IDX) begin
            w_byte = r_chk;
        end else begin
            for (int unsigned d = 0; d < NDATA; d++) begin
                if (r_idx == IDXW'(d + 2)) begin
                    w_byte = r_data[(d / BPA) * BPA * 8 + (BPA - 1 - (d % BPA)) * 8 +: 8];
                end
            end
        end
    end

    assign w_sel    = i_sample_vld && (r_dcnt == '0);
    // A selected strobe coinciding with last-byte completion starts the next frame.
    assign w_accept = w_sel && ((r_state == IDLE) ||
                      ((r_state == WAIT_HIGH) && i_tx_ready && (r_idx == LAST_IDX)));

    // Decimation counter advances on every strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dcnt <= '0;
        end else if (i_sample_vld) begin
            r_dcnt <= (r_dcnt == DLAST) ? '0 : r_dcnt + 8'd1;
        end
    end

    // Saturating count of selected samples that arrive mid-frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop <= '0;
        end else if (w_sel && !w_accept && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    // Frame sequencer: handshake each byte with the UART, accumulate checksum.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_wcnt    <= '0;
            r_data    <= '0;
            r_chk     <= '0;
            r_tx_enb  <= 1'b0;
            r_tx_byte <= '0;
            r_seq     <= '0;
        end else begin
            r_tx_enb <= 1'b0;
            if (w_accept) begin
                r_data  <= w_pad;
                r_seq   <= r_seq + 8'd1;
                r_chk   <= '0;
                r_idx   <= '0;
                r_state <= SEND;
            end else begin
                case (r_state)
                    SEND: begin
                        if (i_tx_ready) begin
                            r_tx_enb  <= 1'b1;
                            r_tx_byte <= w_byte;
                            if ((r_idx != '0) && (r_idx != LAST_IDX)) begin
                                r_chk <= r_chk ^ w_byte;
                            end
                            r_wcnt  <= '0;
                            r_state <= WAIT_LOW;
                        end
                    end
                    WAIT_LOW: begin
                        if (!i_tx_ready || (r_wcnt == 2'd2)) begin
                            r_state <= WAIT_HIGH;
                        end else begin
                            r_wcnt <= r_wcnt + 2'd1;
                        end
                    end
                    WAIT_HIGH: begin
                        if (i_tx_ready) begin
                            if (r_idx == LAST_IDX) begin
                                r_state <= IDLE;
                            end else begin
                                r_idx   <= r_idx + IDXW'(1);
                                r_state <= SEND;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_tx_enb   = r_tx_enb;
    assign o_tx_byte  = r_tx_byte;
    assign o_busy     = (r_state != IDLE);
    assign o_seq      = r_seq;
    assign o_drop_cnt = r_drop;

endmodule

// File: tb/tb_accel_uart_framer.sv
// Directed bench for accel_uart_framer: three instances (defaults, DECIM=4,
// single 12-bit axis) each driven by a simple UART model.
module tb_accel_uart_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [47:0] s0, s1;
    logic [11:0] s2;
    logic        vld0 = 0, vld1 = 0, vld2 = 0;
    logic        rdy0 = 1, rdy1 = 1, rdy2 = 1;
    logic        hold0 = 0, hold1 = 0, hold2 = 0;
    logic        enb0, enb1, enb2;
    logic [7:0]  byte0, byte1, byte2;
    logic        busy0, busy1, busy2;
    logic [7:0]  seq0, seq1, seq2;
    logic [7:0]  drop0, drop1, drop2;
    int          rc0 = 0, rc1 = 0, rc2 = 0;
    logic [7:0]  q0[$], q1[$], q2[$];
    logic [7:0]  exp9 [9];
    logic [7:0]  exp5 [5];
    int          checks = 0;
    int          errors = 0;

    accel_uart_framer u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample(s0), .i_sample_vld(vld0),
        .i_tx_ready(rdy0), .o_tx_enb(enb0), .o_tx_byte(byte0), .o_busy(busy0),
        .o_seq(seq0), .o_drop_cnt(drop0));

    accel_uart_framer #(.DECIM(4)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample(s1), .i_sample_vld(vld1),
        .i_tx_ready(rdy1), .o_tx_enb(enb1), .o_tx_byte(byte1), .o_busy(busy1),
        .o_seq(seq1), .o_drop_cnt(drop1));

    accel_uart_framer #(.NUM_AXES(1), .AXIS_W(12)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample(s2), .i_sample_vld(vld2),
        .i_tx_ready(rdy2), .o_tx_enb(enb2), .o_tx_byte(byte2), .o_busy(busy2),
        .o_seq(seq2), .o_drop_cnt(drop2));

    // UART models: ready drops after each start pulse for ~10 cycles; bytes are captured.
    always @(negedge clk) begin
        if (enb0) q0.push_back(byte0);
        if (enb1) q1.push_back(byte1);
        if (enb2) q2.push_back(byte2);
        if (hold0) rdy0 = 1'b1;
        else if (enb0) begin rdy0 = 1'b0; rc0 = 10; end
        else if (rc0 > 0) begin rc0--; if (rc0 == 0) rdy0 = 1'b1; end
        if (hold1) rdy1 = 1'b1;
        else if (enb1) begin rdy1 = 1'b0; rc1 = 10; end
        else if (rc1 > 0) begin rc1--; if (rc1 == 0) rdy1 = 1'b1; end
        if (hold2) rdy2 = 1'b1;
        else if (enb2) begin rdy2 = 1'b0; rc2 = 10; end
        else if (rc2 > 0) begin rc2--; if (rc2 == 0) rdy2 = 1'b1; end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic busy_of(input int i);
        case (i)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    task automatic pulse(input int i);
        @(negedge clk);
        case (i)
            0: vld0 = 1'b1;
            1: vld1 = 1'b1;
            default: vld2 = 1'b1;
        endcase
        @(negedge clk);
        vld0 = 1'b0; vld1 = 1'b0; vld2 = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int lim);
        int n = 0;
        while (busy_of(i) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, busy_of(i)}, 32'd0);
    endtask

    initial begin
        s0 = {16'h00FF, 16'hABCD, 16'h1234};
        s1 = s0;
        s2 = 12'hFAB;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_seq", {24'd0, seq0}, 32'd0);
        chk("rst_drop", {24'd0, drop0}, 32'd0);
        chk("rst_enb", {31'd0, enb0}, 32'd0);
        chk("rst_byte", {24'd0, byte0}, 32'd0);
        rst_n = 1'b1;

        // Default frame, with a second strobe arriving mid-frame.
        @(negedge clk); vld0 = 1'b1;
        @(negedge clk); vld0 = 1'b0;
        chk("e0_busy", {31'd0, busy0}, 32'd1);
        chk("e0_seq", {24'd0, seq0}, 32'd1);
        chk("e0_enb", {31'd0, enb0}, 32'd0);
        @(negedge clk);
        chk("e1_enb", {31'd0, enb0}, 32'd1);
        chk("e1_byte", {24'd0, byte0}, 32'hA5);
        @(negedge clk);
        chk("e2_enb", {31'd0, enb0}, 32'd0);
        repeat (2) @(negedge clk);
        pulse(0);
        chk("drop_one", {24'd0, drop0}, 32'd1);
        wait_idle(0, 1000);
        exp9[0] = 8'hA5; exp9[1] = 8'h01; exp9[2] = 8'h12; exp9[3] = 8'h34;
        exp9[4] = 8'hAB; exp9[5] = 8'hCD; exp9[6] = 8'h00; exp9[7] = 8'hFF;
        exp9[8] = 8'h01 ^ 8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD ^ 8'h00 ^ 8'hFF;
        chk("f1_count", q0.size(), 32'd9);
        for (int k = 0; k < 9; k++) chk("f1_byte", {24'd0, q0[k]}, {24'd0, exp9[k]});
        chk("f1_seq_keep", {24'd0, seq0}, 32'd1);

        q0.delete();
        pulse(0);
        wait_idle(0, 1000);
        chk("f2_count", q0.size(), 32'd9);
        chk("f2_seq", {24'd0, q0[1]}, 32'h02);
        chk("f2_chk", {24'd0, q0[8]}, {24'd0, 8'h02 ^ 8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD ^ 8'h00 ^ 8'hFF});

        // DECIM=4: eight spaced strobes, only the 1st and 5th are framed.
        for (int k = 0; k < 8; k++) begin
            pulse(1);
            wait_idle(1, 1000);
            repeat (3) @(negedge clk);
        end
        chk("dec_count", q1.size(), 32'd18);
        chk("dec_seq1", {24'd0, q1[1]}, 32'h01);
        chk("dec_seq2", {24'd0, q1[10]}, 32'h02);
        chk("dec_oseq", {24'd0, seq1}, 32'd2);
        chk("dec_drop", {24'd0, drop1}, 32'd0);

        // Single 12-bit axis padded to two bytes.
        pulse(2);
        wait_idle(2, 1000);
        exp5[0] = 8'hA5; exp5[1] = 8'h01; exp5[2] = 8'h0F; exp5[3] = 8'hAB;
        exp5[4] = 8'h01 ^ 8'h0F ^ 8'hAB;
        chk("w12_count", q2.size(), 32'd5);
        for (int k = 0; k < 5; k++) chk("w12_byte", {24'd0, q2[k]}, {24'd0, exp5[k]});

        // Sequence wrap across 256 frames.
        for (int k = 0; k < 254; k++) begin
            pulse(2);
            wait_idle(2, 1000);
        end
        chk("wrap_ff", {24'd0, seq2}, 32'hFF);
        q2.delete();
        pulse(2);
        wait_idle(2, 1000);
        chk("wrap_seqbyte", {24'd0, q2[1]}, 32'h00);
        chk("wrap_chk", {24'd0, q2[4]}, {24'd0, 8'h00 ^ 8'h0F ^ 8'hAB});
        chk("wrap_oseq", {24'd0, seq2}, 32'h00);

        // Drop counter saturation.
        @(negedge clk); vld2 = 1'b1;
        repeat (300) @(negedge clk);
        vld2 = 1'b0;
        chk("drop_sat", {24'd0, drop2}, 32'hFF);
        wait_idle(2, 2000);
        pulse(2);
        pulse(2);
        chk("drop_hold", {24'd0, drop2}, 32'hFF);
        wait_idle(2, 1000);

        // Reset during the 4th byte of a frame.
        q0.delete();
        pulse(0);
        begin
            int n = 0;
            while (q0.size() < 4 && n < 1000) begin @(negedge clk); n++; end
        end
        chk("rst4_reached", q0.size(), 32'd4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy0}, 32'd0);
        chk("arst_seq", {24'd0, seq0}, 32'd0);
        chk("arst_drop", {24'd0, drop0}, 32'd0);
        chk("arst_enb", {31'd0, enb0}, 32'd0);
        chk("arst_byte", {24'd0, byte0}, 32'd0);
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("arst_no_enb", q0.size(), 32'd4);
        q0.delete();
        pulse(0);
        wait_idle(0, 1000);
        chk("arst_count", q0.size(), 32'd9);
        chk("arst_seqbyte", {24'd0, q0[1]}, 32'h01);

        // Ready held high: WAIT_LOW timeout carries the frame through.
        hold0 = 1'b1;
        @(negedge clk);
        q0.delete();
        pulse(0);
        wait_idle(0, 1000);
        chk("hold_count", q0.size(), 32'd9);
        chk("hold_seqbyte", {24'd0, q0[1]}, 32'h02);
        chk("hold_chk", {24'd0, q0[8]}, {24'd0, 8'h02 ^ 8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD ^ 8'h00 ^ 8'hFF});
        chk("hold_sync", {24'd0, q0[0]}, 32'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
